// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the RV32M sequential divider.
//   - div_state_e : sequencing FSM states
//   - DIV_Q/DIV_R/DIV_S : bit positions inside the 3-bit div_op
//   - DIV_STEPS, INT_MIN, ALL_ONES : datapath constants
//   - abs32() : conditional two's-complement magnitude
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_e;

    localparam int DIV_Q = 2;   // quotient requested
    localparam int DIV_R = 1;   // remainder requested
    localparam int DIV_S = 0;   // signed operation

    localparam int          DIV_STEPS = 32;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

    // Magnitude of v when en is set and v is negative; INT_MIN maps onto
    // itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_seq_unit_clz32.sv
// clz32: combinational count-leading-zeros of a 32-bit word.
// Ports:
//   a   in  32  value to scan
//   cnt out 6   number of leading zeros, 32 when a == 0
module clz32 (
    input  logic [31:0] a,
    output logic [5:0]  cnt
);

    // Scan from LSB to MSB; the highest set bit is the last to write cnt.
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) cnt = 6'(31 - i);
        end
    end

endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle radix-2 restoring divider for the RV32M execute
// stage. Accepts {div, rem, signed} ops, handles divide-by-zero and signed
// overflow in the prep cycle, and returns one 32-bit result under valid/ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             kill any in-flight operation (result register retained)
//   in_valid/in_ready request handshake; in_ready only in IDLE
//   div_op[2:0]       {quotient, remainder, signed}
//   src1, src2        dividend, divisor
//   out_valid/out_ready result handshake; result held while out_valid
//   result            quotient or remainder
//   busy              FSM not in IDLE
//
// Build option: DIV_EARLY_OUT_EN skips the leading-zero iterations of the
// dividend using clz32 (latency 3 + significant bits, identical results).
module div_seq_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      div_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    div_state_e  state_q, state_d;

    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;       // raw latched operands
    logic [31:0] dsr_q;          // divisor magnitude
    logic [31:0] rem_q;          // partial remainder (upper half of shifter)
    logic [31:0] quo_q;          // dividend bits shifting out, quotient in
    logic [5:0]  cnt_q, steps_q;
    logic        q_neg_q, r_neg_q;
    logic [31:0] result_q;

    logic        accept;
    logic        is_signed;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, ovf;
    logic [31:0] prep_dvd;
    logic [5:0]  prep_steps;
    logic        skip_calc;
    logic        last_step;

    // ---------------------------------------------------------------
    // Prep-cycle operand analysis (operates on latched operands)
    // ---------------------------------------------------------------
    assign is_signed = op_q[DIV_S];
    assign a_mag     = abs32(a_q, is_signed);
    assign b_mag     = abs32(b_q, is_signed);
    assign div_zero  = (b_q == 32'd0);
    assign ovf       = is_signed && (a_q == INT_MIN) && (b_q == ALL_ONES);

`ifdef DIV_EARLY_OUT_EN
    logic [5:0] clz;

    clz32 u_clz (
        .a   (a_mag),
        .cnt (clz)
    );

    // Leading zeros of the dividend produce only zero quotient bits and
    // leave the remainder at zero, so they can be shifted past up front.
    assign prep_dvd   = a_mag << clz;
    assign prep_steps = 6'(DIV_STEPS) - clz;
    assign skip_calc  = (clz == 6'd32);
`else
    assign prep_dvd   = a_mag;
    assign prep_steps = 6'(DIV_STEPS);
    assign skip_calc  = 1'b0;
`endif

    // ---------------------------------------------------------------
    // One restoring step: 33-bit trial subtract so the shifted-out
    // remainder MSB is not lost.
    // ---------------------------------------------------------------
    logic [32:0] rem_sh, diff;
    logic        q_bit;
    logic [31:0] step_rem;

    assign rem_sh   = {rem_q, quo_q[31]};
    assign diff     = rem_sh - {1'b0, dsr_q};
    assign q_bit    = ~diff[32];
    assign step_rem = q_bit ? diff[31:0] : rem_sh[31:0];
    assign last_step = (cnt_q == steps_q - 6'd1);

    // ---------------------------------------------------------------
    // Sign fix-up and result select
    // ---------------------------------------------------------------
    logic [31:0] q_fix, r_fix, fix_result;
    logic        sel_rem;

    // Remainder only when it alone is requested; any other nonzero op
    // returns the quotient.
    assign sel_rem    = op_q[DIV_R] && !op_q[DIV_Q];
    assign q_fix      = (q_neg_q && quo_q != 32'd0) ? (~quo_q + 32'd1) : quo_q;
    assign r_fix      = (r_neg_q && rem_q != 32'd0) ? (~rem_q + 32'd1) : rem_q;
    assign fix_result = sel_rem ? r_fix : q_fix;

    assign accept = in_valid && in_ready && !flush && (div_op != 3'd0);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_PREP;
            ST_PREP: begin
                if (div_zero || ovf) state_d = ST_DONE;
                else if (skip_calc)  state_d = ST_FIX;
                else                 state_d = ST_CALC;
            end
            ST_CALC: if (last_step) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides accept and the output handshake alike.
        if (flush) state_d = ST_IDLE;
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            dsr_q    <= 32'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            cnt_q    <= 6'd0;
            steps_q  <= 6'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= 32'd0;
        end else begin
            if (accept) begin
                op_q <= div_op;
                a_q  <= src1;
                b_q  <= src2;
            end
            case (state_q)
                ST_PREP: begin
                    q_neg_q <= is_signed && (a_q[31] ^ b_q[31]);
                    r_neg_q <= is_signed && a_q[31];
                    dsr_q   <= b_mag;
                    rem_q   <= 32'd0;
                    quo_q   <= prep_dvd;
                    cnt_q   <= 6'd0;
                    steps_q <= prep_steps;
                    // Special cases resolve here; a flushed op never
                    // disturbs the previously delivered result.
                    if (!flush) begin
                        if (div_zero)
                            result_q <= sel_rem ? a_q : ALL_ONES;
                        else if (ovf)
                            result_q <= sel_rem ? 32'd0 : INT_MIN;
                    end
                end
                ST_CALC: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[30:0], q_bit};
                    cnt_q <= cnt_q + 6'd1;
                end
                ST_FIX: begin
                    if (!flush) result_q <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_seq_unit.sv
module tb_div_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  div_op;
    logic [31:0] src1, src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div_op    (div_op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 32'd0;
            end else begin
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b; r = a % b;
        end
        return (op[1] && !op[2]) ? r : q;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] mag;
        int lz;
        if (b == 32'd0 || (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
        mag = (op[0] && a[31]) ? -a : a;
        lz = 0;
        while (lz < 32 && !mag[31 - lz]) lz++;
`ifdef DIV_EARLY_OUT_EN
        return 3 + (32 - lz);
`else
        return 35 + 0 * lz;
`endif
    endfunction

    // Issue one op with out_ready high; check latency and result.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        logic [31:0] exp;
        int elat, n;
        exp  = ref_div(op, a, b);
        elat = ref_lat(op, a, b);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s in_ready before issue got %b want 1", name, in_ready);
        end
        div_op = op; src1 = a; src2 = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n != elat) begin
            errors++; $display("FAIL %s latency got %0d want %0d", name, n, elat);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result op=%b a=%h b=%h got %h want %h", name, op, a, b, result, exp);
        end
        @(posedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        div_op = 3'd0; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got ov=%b busy=%b ir=%b res=%h want 0 0 1 0",
                     out_valid, busy, in_ready, result);
        end
    endtask

    task automatic test_directed();
        run_op(3'b100, 32'd100, 32'd7, "divu_100_7");
        run_op(3'b010, 32'd100, 32'd7, "remu_100_7");
        run_op(3'b101, -32'sd7, 32'd2, "div_m7_2");
        run_op(3'b011, -32'sd7, 32'd2, "rem_m7_2");
        run_op(3'b011, -32'sd7, -32'sd2, "rem_m7_m2");
        run_op(3'b101, 32'h1234, 32'd0, "div_by_zero");
        run_op(3'b011, 32'h1234, 32'd0, "rem_by_zero");
        run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "divu_ovf_ops");
        run_op(3'b100, 32'd5, 32'd3, "divu_5_3");
        run_op(3'b101, 32'd0, 32'd9, "div_zero_dividend");
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        div_op = 3'b100; src1 = 32'd100; src2 = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_reach_done out_valid got %b want 1", out_valid);
        end
        // A new request during DONE must be ignored.
        in_valid = 1'b1; div_op = 3'b100; src1 = 32'd999; src2 = 32'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got ov=%b res=%h ir=%b want 1 0000000e 0",
                         i, out_valid, result, in_ready);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL bp_no_accept busy got %b want 0", busy);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        prev = result;
        @(negedge clk);
        div_op = 3'b100; src1 = 32'hDEAD_BEEF; src2 = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);   // cycle 12: CALC step 10
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL flush_busy_before got %b want 1", busy);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL flush_calc got busy=%b ir=%b ov=%b res=%h want 0 1 0 %h",
                     busy, in_ready, out_valid, result, prev);
        end
        begin
            bit seen = 1'b0;
            repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen = 1'b1; end
            checks++;
            if (seen) begin errors++; $display("FAIL flush_no_valid out_valid rose after flush"); end
        end
        run_op(3'b100, 32'hDEAD_BEEF, 32'd3, "after_flush");
        // Flush coincident with a request: nothing is accepted.
        @(negedge clk);
        div_op = 3'b101; src1 = 32'd50; src2 = 32'd5; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_vs_accept got busy=%b ir=%b want 0 1", busy, in_ready);
        end
        // Flush in DONE beats out_ready; register keeps the computed value.
        @(negedge clk);
        div_op = 3'b101; src1 = 32'd50; src2 = 32'd5; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (60) begin if (out_valid !== 1'b1) @(negedge clk); end
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd10) begin
            errors++;
            $display("FAIL flush_done got ov=%b busy=%b res=%h want 0 0 0000000a", out_valid, busy, result);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        div_op = 3'b100; src1 = 32'd77; src2 = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midop got busy=%b ov=%b res=%h ir=%b want 0 0 0 1",
                     busy, out_valid, result, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp;
        int k, elat;
        a = $urandom; b = $urandom_range(1, 1000);
        exp = ref_div(3'b100, a, b);
        elat = ref_lat(3'b100, a, b);
        @(negedge clk);
        div_op = 3'b100; src1 = a; src2 = b; in_valid = 1'b1; out_ready = 1'b1;
        k = 0;
        while (out_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        checks++;
        if (result !== exp) begin
            errors++; $display("FAIL b2b_first got %h want %h", result, exp);
        end
        k = 0;
        do begin @(negedge clk); k++; end while (out_valid !== 1'b1 && k < 200);
        in_valid = 1'b0;
        checks++;
        if (k != elat + 1) begin
            errors++; $display("FAIL b2b_interval got %0d want %0d", k, elat + 1);
        end
        checks++;
        if (result !== exp) begin
            errors++; $display("FAIL b2b_second got %h want %h", result, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0] ops [4];
        logic [2:0] op;
        logic [31:0] a, b;
        ops[0] = 3'b100; ops[1] = 3'b010; ops[2] = 3'b101; ops[3] = 3'b011;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 3)];
            a = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
                2: b = $urandom_range(1, 15);
                3: begin a = $urandom_range(0, 40); b = $urandom_range(1, 9); end
                4: b = -$urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op(op, a, b, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
